// File: rtl/spi_flash_sequencer.sv
// SPI NOR flash command sequencer, mode 0.
// Runs opcode/address/dummy/data phases from one latched descriptor.
module spi_flash_sequencer #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic        cmd_has_addr,
  input  logic [23:0] cmd_addr,
  input  logic [3:0]  cmd_dummy,
  input  logic [8:0]  cmd_len,
  input  logic        cmd_write,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        s_clk,
  output logic        s_css,
  output logic        s_mosi,
  input  logic        s_miso
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CS_SETUP = 4'd1;
  localparam logic [3:0] OPCODE   = 4'd2;
  localparam logic [3:0] ADDR     = 4'd3;
  localparam logic [3:0] DUMMY    = 4'd4;
  localparam logic [3:0] DATA     = 4'd5;
  localparam logic [3:0] WR_WAIT  = 4'd6;
  localparam logic [3:0] CS_HOLD  = 4'd7;
  localparam logic [3:0] GAP      = 4'd8;

  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
  localparam logic [7:0]    DIV_END = 8'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC - 1);

  logic [3:0]    state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    tx_q, tx_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    op_q, op_d;
  logic          ha_q, ha_d;
  logic [23:0]   addr_q, addr_d;
  logic [3:0]    dum_q, dum_d;
  logic [8:0]    len_q, len_d;
  logic          wr_q, wr_d;
  logic          sclk_q, sclk_d;
  logic          css_q, css_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdv_q, rdv_d;
  logic [7:0]    rdd_q, rdd_d;
  logic          wrr_c;
  logic          half_end;
  logic [3:0]    nx_st;
  logic [8:0]    nx_cnt;

  assign half_end  = (div_q == DIV_END);
  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = wrr_c & ~p_reset;
  assign rd_data   = rdd_q;
  assign rd_valid  = rdv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign s_clk     = sclk_q;
  assign s_css     = css_q;
  assign s_mosi    = mosi_q;

  // Phase that follows the byte now ending; later rules take priority.
  always_comb begin
    nx_st  = CS_HOLD;
    nx_cnt = 9'd0;
    if (state_q != DATA && len_q != 9'd0) begin
      nx_st  = DATA;
      nx_cnt = len_q;
    end
    if ((state_q == OPCODE || state_q == ADDR) &&
        dum_q != 4'd0) begin
      nx_st  = DUMMY;
      nx_cnt = {5'd0, dum_q};
    end
    if (state_q == OPCODE && ha_q) begin
      nx_st  = ADDR;
      nx_cnt = 9'd3;
    end
    if (cnt_q != 9'd1) begin
      nx_st  = state_q;
      nx_cnt = cnt_q - 9'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    op_d    = op_q;
    ha_d    = ha_q;
    addr_d  = addr_q;
    dum_d   = dum_q;
    len_d   = len_q;
    wr_d    = wr_q;
    sclk_d  = sclk_q;
    css_d   = css_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    wrr_c   = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_opcode;
        ha_d    = cmd_has_addr;
        addr_d  = cmd_addr;
        dum_d   = cmd_dummy;
        len_d   = cmd_len;
        wr_d    = cmd_write;
        state_d = CS_SETUP;
        div_d   = 8'd0;
        busy_d  = 1'b1;
        css_d   = 1'b0;
      end
      CS_SETUP: begin
        div_d = div_q + 8'd1;
        if (half_end) begin
          state_d = OPCODE;
          div_d   = 8'd0;
          bit_d   = 3'd0;
          cnt_d   = 9'd1;
          mosi_d  = op_q[7];
          tx_d    = op_q[6:0];
        end
      end
      OPCODE, ADDR, DUMMY, DATA: begin
        div_d = div_q + 8'd1;
        if (half_end && !sclk_q) begin
          div_d  = 8'd0;
          sclk_d = 1'b1;
          rx_d   = {rx_q[5:0], s_miso};
          if (state_q == DATA && !wr_q && bit_q == 3'd7) begin
            rdv_d = 1'b1;
            rdd_d = {rx_q, s_miso};
          end
        end else if (half_end) begin
          div_d  = 8'd0;
          sclk_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end else begin
            bit_d   = 3'd0;
            state_d = nx_st;
            cnt_d   = nx_cnt;
            mosi_d  = 1'b0;
            tx_d    = 7'd0;
            if (nx_st == ADDR) begin
              mosi_d = addr_q[23];
              tx_d   = addr_q[22:16];
              addr_d = {addr_q[15:0], 8'h00};
            end else if (nx_st == DATA && wr_q) begin
              wrr_c = 1'b1;
              if (wr_valid) begin
                mosi_d = wr_data[7];
                tx_d   = wr_data[6:0];
              end else begin
                state_d = WR_WAIT;
              end
            end
          end
        end
      end
      WR_WAIT: begin
        wrr_c = 1'b1;
        if (wr_valid) begin
          state_d = DATA;
          div_d   = 8'd0;
          mosi_d  = wr_data[7];
          tx_d    = wr_data[6:0];
        end
      end
      CS_HOLD: begin
        div_d = div_q + 8'd1;
        if (half_end) begin
          state_d = GAP;
          div_d   = 8'd0;
          gap_d   = '0;
          css_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_END) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 9'd0;
      gap_q   <= '0;
      tx_q    <= 7'd0;
      rx_q    <= 7'd0;
      op_q    <= 8'd0;
      ha_q    <= 1'b0;
      addr_q  <= 24'd0;
      dum_q   <= 4'd0;
      len_q   <= 9'd0;
      wr_q    <= 1'b0;
      sclk_q  <= 1'b0;
      css_q   <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      op_q    <= op_d;
      ha_q    <= ha_d;
      addr_q  <= addr_d;
      dum_q   <= dum_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      sclk_q  <= sclk_d;
      css_q   <= css_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a bit-stream flash model.
// Expected MOSI/MISO streams are built per transaction from the descriptor.
module tb_spi_flash_sequencer;
  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 4;

  logic p_clk = 0, p_reset = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [7:0] cmd_opcode = 0;
  logic cmd_has_addr = 0;
  logic [23:0] cmd_addr = 0;
  logic [3:0] cmd_dummy = 0;
  logic [8:0] cmd_len = 0;
  logic cmd_write = 0;
  logic [7:0] wr_data;
  logic wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic rd_valid, busy, done, s_clk, s_css, s_mosi, s_miso;

  spi_flash_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_has_addr(cmd_has_addr),
    .cmd_addr(cmd_addr), .cmd_dummy(cmd_dummy),
    .cmd_len(cmd_len), .cmd_write(cmd_write),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi), .s_miso(s_miso));

  always #5 p_clk = ~p_clk;

  int n_chk = 0, n_err = 0;
  int exp_bit [0:4095];
  logic miso_bit [0:4095];
  logic cap_bit [0:4095];
  logic [7:0] wdat [0:255];
  logic [7:0] rdat [0:255];
  logic [7:0] rd_q [$];
  logic [7:0] rd_got [$];
  int rise_cnt = 0, hdr_bits = 0, rd_cnt = 0, done_cnt = 0;
  int css_low = 0, css_fall = 0, hi_run = 0, last_hi_run = 0;
  int cyc = 0, t_done = 0, t_acc = 0, ready_gap = 0;
  logic prev_clk = 0, prev_mosi = 0, prev_css = 1;
  logic prev_ready = 0, prev_wrr = 0;
  int wr_idx = 0, wr_n = 0, stall_idx = -1, stall_n = 0, seen = 0;

  assign s_miso = miso_bit[rise_cnt[11:0]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] cap_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = cap_bit[8*k+i];
    return b;
  endfunction

  // Per-cycle compare process against the stream model.
  always @(posedge p_clk) begin
    #1;
    cyc++;
    if (prev_ready && cmd_valid) t_acc = cyc;
    if (s_css) chk("sclk_idle_when_cs_high", s_clk, 0);
    if (prev_clk && s_clk) chk("mosi_stable_while_high", s_mosi, prev_mosi);
    if (s_clk && !prev_clk) begin
      if (exp_bit[rise_cnt[11:0]] != 2)
        chk("mosi_bit", s_mosi, exp_bit[rise_cnt[11:0]]);
      cap_bit[rise_cnt[11:0]] = s_mosi;
      rise_cnt++;
    end
    if (rd_valid) begin
      rd_cnt++;
      rd_got.push_back(rd_data);
      chk("rd_expected", rd_q.size() != 0, 1);
      if (rd_q.size() != 0) chk("rd_data", rd_data, rd_q.pop_front());
      chk("rd_timing", s_clk && !prev_clk && (rise_cnt % 8 == 0) &&
          (rise_cnt > hdr_bits), 1);
    end
    if (wr_ready && prev_wrr) begin
      chk("stall_sclk_low", s_clk, 0);
      chk("stall_css_low", s_css, 0);
    end
    if (!s_css) css_low++;
    if (!s_css && prev_css) begin css_fall++; last_hi_run = hi_run; end
    hi_run = s_css ? hi_run + 1 : 0;
    if (done) begin done_cnt++; t_done = cyc; end
    if (cmd_ready && !prev_ready) ready_gap = cyc - t_done;
    prev_clk = s_clk; prev_mosi = s_mosi; prev_css = s_css;
    prev_ready = cmd_ready; prev_wrr = wr_ready;
  end

  // Write-data source; withholds byte stall_idx for stall_n ready cycles.
  initial begin
    wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge p_clk);
      wr_valid = (wr_idx < wr_n) && !(wr_idx == stall_idx && seen < stall_n);
      wr_data = wdat[wr_idx[7:0]];
      if (wr_ready && wr_valid) wr_idx++;
      else if (wr_ready && wr_idx == stall_idx) seen++;
    end
  end

  task automatic prep(input logic [7:0] op, input logic ha,
                      input logic [23:0] ad, input logic [3:0] dm,
                      input logic [8:0] ln, input logic wr);
    int p;
    for (int i = 0; i < 4096; i++) begin exp_bit[i] = 2; miso_bit[i] = 0; end
    for (int i = 0; i < 8; i++) exp_bit[i] = int'(op[7-i]);
    p = 8;
    if (ha) begin
      for (int i = 0; i < 24; i++) exp_bit[p+i] = int'(ad[23-i]);
      p += 24;
    end
    for (int i = 0; i < 8 * int'(dm); i++) exp_bit[p+i] = 0;
    p += 8 * int'(dm);
    hdr_bits = p;
    rd_q.delete(); rd_got.delete();
    for (int k = 0; k < int'(ln); k++) begin
      for (int i = 0; i < 8; i++)
        if (wr) exp_bit[p+8*k+i] = int'(wdat[k][7-i]);
        else miso_bit[p+8*k+i] = rdat[k][7-i];
      if (!wr) rd_q.push_back(rdat[k]);
    end
    rise_cnt = 0; rd_cnt = 0; done_cnt = 0; css_low = 0; css_fall = 0;
    seen = 0; wr_idx = 0; wr_n = wr ? int'(ln) : 0;
    cmd_opcode = op; cmd_has_addr = ha; cmd_addr = ad;
    cmd_dummy = dm; cmd_len = ln; cmd_write = wr;
  endtask

  task automatic wait_accept();
    int to = 0;
    while (!cmd_ready && to < 100) begin @(negedge p_clk); to++; end
    chk("accept_within_bound", to < 100, 1);
    @(negedge p_clk);
  endtask

  task automatic wait_done();
    int to = 0;
    while (done_cnt == 0 && to < 5000) begin @(negedge p_clk); to++; end
    chk("done_within_bound", done_cnt != 0, 1);
  endtask

  task automatic run_txn(input string nm, input logic [7:0] op,
                         input logic ha, input logic [23:0] ad,
                         input logic [3:0] dm, input logic [8:0] ln,
                         input logic wr, input bit glitch,
                         input int e_rise, input int e_css);
    int to;
    @(negedge p_clk);
    prep(op, ha, ad, dm, ln, wr);
    cmd_valid = 1;
    wait_accept();
    cmd_valid = 0;
    to = 0;
    while (done_cnt == 0 && to < 5000) begin
      @(negedge p_clk); to++;
      if (glitch && to == 20) begin cmd_valid = 1; cmd_opcode = 8'hFF; end
      if (glitch && to == 21) cmd_valid = 0;
    end
    chk({nm, "_done_bound"}, done_cnt != 0, 1);
    to = 0;
    while (!cmd_ready && to < 50) begin @(negedge p_clk); to++; end
    repeat (6) @(negedge p_clk);
    chk({nm, "_rises"}, rise_cnt, e_rise);
    chk({nm, "_css_low_cycles"}, css_low, e_css);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_css_fall_count"}, css_fall, 1);
    chk({nm, "_rd_count"}, rd_cnt, wr ? 0 : int'(ln));
    chk({nm, "_rd_left"}, rd_q.size(), 0);
    chk({nm, "_wr_consumed"}, wr_idx, wr ? int'(ln) : 0);
    chk({nm, "_ready_gap"}, ready_gap, GAP_CYC);
  endtask

  initial begin
    logic [7:0] pp [0:5];
    int to;
    pp = '{8'h02, 8'h01, 8'h23, 8'h45, 8'hA5, 8'h5A};
    repeat (3) @(negedge p_clk);
    chk("rst_css", s_css, 1);
    chk("rst_sclk", s_clk, 0);
    chk("rst_mosi", s_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    p_reset = 0;
    @(negedge p_clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    rdat[0] = 8'hEF; rdat[1] = 8'h40; rdat[2] = 8'h18;
    run_txn("read_id", 8'h9F, 0, 24'h0, 4'd0, 9'd3, 0, 1, 32, 132);
    chk("read_id_op_byte", cap_byte(0), 8'h9F);
    chk("read_id_rd0", rd_got[0], 8'hEF);
    chk("read_id_rd1", rd_got[1], 8'h40);
    chk("read_id_rd2", rd_got[2], 8'h18);

    run_txn("wren", 8'h06, 0, 24'h0, 4'd0, 9'd0, 0, 0, 8, 36);

    wdat[0] = 8'hA5; wdat[1] = 8'h5A; stall_idx = 1; stall_n = 10;
    run_txn("pp", 8'h02, 1, 24'h012345, 4'd0, 9'd2, 1, 0, 48, 206);
    for (int k = 0; k < 6; k++) chk("pp_mosi_byte", cap_byte(k), pp[k]);
    stall_idx = -1;

    rdat[0] = 8'h3C;
    run_txn("fast_rd", 8'h0B, 1, 24'h000100, 4'd1, 9'd1, 0, 0, 48, 196);
    chk("fast_rd_rd0", rd_got[0], 8'h3C);
    chk("fast_rd_dummy_byte", cap_byte(4), 8'h00);
    chk("fast_rd_addr_lo", cap_byte(3), 8'h00);

    @(negedge p_clk);
    prep(8'h03, 1, 24'h123456, 4'd0, 9'd4, 0);
    cmd_valid = 1;
    wait_accept();
    cmd_valid = 0;
    to = 0;
    while (rise_cnt < 12 && to < 1000) begin @(negedge p_clk); to++; end
    chk("rst_mid_reach_addr", rise_cnt >= 12, 1);
    p_reset = 1;
    @(negedge p_clk);
    chk("abort_css", s_css, 1);
    chk("abort_sclk", s_clk, 0);
    chk("abort_busy", busy, 0);
    p_reset = 0;
    repeat (10) @(negedge p_clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_ready", cmd_ready, 1);
    run_txn("after_abort", 8'h06, 0, 24'h0, 4'd0, 9'd0, 0, 0, 8, 36);

    @(negedge p_clk);
    prep(8'h06, 0, 24'h0, 4'd0, 9'd0, 0);
    cmd_valid = 1;
    wait_accept();
    cmd_opcode = 8'h04;
    wait_done();
    prep(8'h04, 0, 24'h0, 4'd0, 9'd0, 0);
    cmd_valid = 1;
    to = 0;
    while (t_acc <= t_done && to < 100) begin @(negedge p_clk); to++; end
    chk("b2b_second_accept_delay", t_acc - t_done, GAP_CYC + 1);
    chk("b2b_css_high_min", last_hi_run >= GAP_CYC, 1);
    cmd_valid = 0;
    wait_done();
    repeat (8) @(negedge p_clk);
    chk("b2b_rises", rise_cnt, 8);
    chk("b2b_css_low", css_low, 36);
    chk("b2b_done_count", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
